// File: rtl/fixed_to_ieee.sv
// fixed_to_ieee: converts a signed two's-complement fixed-point word with
// FRAC_BITS fractional bits into an IEEE-754 single-precision float.
// The fractional scaling is folded into the starting exponent, so no divider
// is needed. Uses stb/ack handshakes on input and output.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   GET_A     | ready for an operand (input_a_ack high)
//   UNPACK    | split sign/magnitude, load starting exponent, detect zero
//   NORMALISE | shift magnitude left one bit per cycle until bit 31 set
//   ROUND     | round-to-nearest-even onto a 24-bit mantissa
//   PACK      | assemble {sign, biased exponent, fraction} into output_z
//   PUT_Z     | result offered (output_z_stb high) until acknowledged
module fixed_to_ieee #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  // Biased exponent of a magnitude whose MSB sits in bit 31:
  // (31 - FRAC_BITS) + 127. Range over legal FRAC_BITS stays inside 8 bits,
  // and the exponent is carried biased throughout.
  localparam logic [7:0] EXP_INIT = 8'(158 - FRAC_BITS);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a_reg;
  logic [31:0] m;
  logic        sign;
  logic [7:0]  exp_b;
  logic [22:0] frac;
  logic        ack_nxt;
  logic        stb_nxt;
  logic        round_up;
  logic        carry;
  logic [22:0] frac_inc;

  // Rounding terms on the normalised magnitude. A carry out of the 24-bit
  // mantissa only happens when m[31:8] is all ones; the 23-bit fraction then
  // wraps to zero, which is exactly the 1.0 x 2^(e+1) encoding.
  assign round_up = m[7] & ((|m[6:0]) | m[8]);
  assign carry    = round_up & (&m[31:8]);
  assign frac_inc = m[30:8] + 23'(round_up);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= GET_A;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:     if (input_a_stb && input_a_ack) state_nxt = UNPACK;
      UNPACK:    state_nxt = (a_reg == 32'd0) ? PUT_Z : NORMALISE;
      NORMALISE: if (m[31]) state_nxt = ROUND;
      ROUND:     state_nxt = PACK;
      PACK:      state_nxt = PUT_Z;
      PUT_Z:     if (output_z_stb && output_z_ack) state_nxt = GET_A;
      default:   state_nxt = GET_A;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered below,
  // so ack/stb change on the same edge that the state does.
  always_comb begin
    ack_nxt = (state_nxt == GET_A);
    stb_nxt = (state_nxt == PUT_Z);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      input_a_ack  <= ack_nxt;
      output_z_stb <= stb_nxt;
    end
  end

  // Datapath: capture, unpack, normalise, round and pack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= 32'd0;
      m        <= 32'd0;
      sign     <= 1'b0;
      exp_b    <= 8'd0;
      frac     <= 23'd0;
      output_z <= 32'd0;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_stb && input_a_ack) a_reg <= input_a;
        end
        UNPACK: begin
          sign  <= a_reg[31];
          m     <= a_reg[31] ? (~a_reg + 32'd1) : a_reg;
          exp_b <= EXP_INIT;
          if (a_reg == 32'd0) output_z <= 32'd0;
        end
        NORMALISE: begin
          if (!m[31]) begin
            m     <= m << 1;
            exp_b <= exp_b - 8'd1;
          end
        end
        ROUND: begin
          frac  <= frac_inc;
          exp_b <= exp_b + 8'(carry);
        end
        PACK: begin
          output_z <= {sign, exp_b, frac};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_ieee.sv
// Testbench for fixed_to_ieee: directed and random conversions checked
// against an arithmetic reference model, plus handshake and reset behaviour.
module tb_fixed_to_ieee;

  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int errors = 0;

  fixed_to_ieee #(.FRAC_BITS(FRAC)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Position of the most significant set bit of a positive value.
  function automatic int msb_pos(input longint mag);
    int p = 0;
    for (int i = 0; i < 40; i++)
      if (mag >= (64'sd1 <<< i)) p = i;
    return p;
  endfunction

  // Reference: value = a / 2^FRAC, rounded to nearest-even single precision.
  function automatic logic [31:0] ref_float(input logic [31:0] a);
    longint sv, mag, q, rem, half;
    int p, sh, e;
    logic s;
    logic [63:0] qb;
    logic [31:0] eb;
    sv = longint'($signed(a));
    if (sv == 0) return 32'd0;
    s   = (sv < 0);
    mag = s ? -sv : sv;
    p   = msb_pos(mag);
    e   = p - FRAC + 127;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >>> sh;
      rem  = mag - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        e = e + 1;
      end
    end else begin
      q = mag <<< (23 - p);
    end
    qb = q;
    eb = e;
    return {s, eb[7:0], qb[22:0]};
  endfunction

  // Expected edges from accept to output_z_stb: leading zeros + 4, or 1 for zero.
  function automatic int ref_lat(input logic [31:0] a);
    longint sv, mag;
    sv = longint'($signed(a));
    if (sv == 0) return 1;
    mag = (sv < 0) ? -sv : sv;
    return (31 - msb_pos(mag)) + 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for input_a_ack, present the operand through the accept edge.
  task automatic send(input logic [31:0] a);
    int n = 0;
    while (input_a_ack !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ack_ready", {31'd0, input_a_ack}, 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    chk("ack_drop_on_accept", {31'd0, input_a_ack}, 32'd0);
  endtask

  task automatic wait_z(output int lat);
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    logic [31:0] held;
    held = output_z;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk("stb_drop_on_take", {31'd0, output_z_stb}, 32'd0);
    chk("ack_back_on_take", {31'd0, input_a_ack}, 32'd1);
    chk("z_kept_after_take", output_z, held);
  endtask

  task automatic convert(input logic [31:0] a, input logic [31:0] expv, input string tag);
    int lat;
    send(a);
    wait_z(lat);
    chk({tag, "_value"}, output_z, expv);
    chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(a)));
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] z0;
    int lat;

    rst          = 1'b0;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #1;
    chk("reset_z",   output_z, 32'd0);
    chk("reset_stb", {31'd0, output_z_stb}, 32'd0);
    chk("reset_ack", {31'd0, input_a_ack}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("ack_first_edge", {31'd0, input_a_ack}, 32'd1);

    // Directed conversions with hand-derived results.
    convert(32'h00010000, 32'h3F800000, "one");
    chk("one_latency_19", 32'(ref_lat(32'h00010000)), 32'd19);
    convert(32'hFFFF8000, 32'hBF000000, "neg_half");
    convert(32'h80000000, 32'hC7000000, "most_neg");
    convert(32'h00000000, 32'h00000000, "zero");
    convert(32'h7FFFFFFF, 32'h47000000, "round_carry");
    convert(32'h01000001, 32'h43800000, "tie_even");
    convert(32'h01000003, 32'h43800002, "tie_odd");
    convert(32'h00000001, 32'h37800000, "lsb_only");

    // Random operands across all magnitudes and both signs.
    for (int i = 0; i < 60; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      convert(a, ref_float(a), "random");
    end

    // Output held while output_z_ack is low; input strobes ignored.
    send(32'h00010000);
    wait_z(lat);
    chk("hold_value", output_z, 32'h3F800000);
    z0 = output_z;
    for (int i = 0; i < 10; i++) begin
      input_a     = 32'h12345678;
      input_a_stb = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_stb", {31'd0, output_z_stb}, 32'd1);
      chk("hold_z",   output_z, z0);
      chk("hold_ack", {31'd0, input_a_ack}, 32'd0);
    end
    // Ack one cycle and present the next operand immediately.
    output_z_ack = 1'b1;
    input_a      = 32'hFFFF8000;
    input_a_stb  = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk("b2b_stb_drop", {31'd0, output_z_stb}, 32'd0);
    chk("b2b_ack_up",   {31'd0, input_a_ack}, 32'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    chk("b2b_accepted", {31'd0, input_a_ack}, 32'd0);
    wait_z(lat);
    chk("b2b_value",   output_z, 32'hBF000000);
    chk("b2b_latency", 32'(lat), 32'd20);
    take();

    // Reset in the middle of normalisation.
    send(32'h00000001);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_z",   output_z, 32'd0);
    chk("midrst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("midrst_ack", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ack_held", {31'd0, input_a_ack}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ack", {31'd0, input_a_ack}, 32'd1);
    convert(32'h00010000, 32'h3F800000, "postrst_one");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_to_ieee.md
Name: fixed_to_ieee

Overview:
- Converts one signed two's-complement fixed-point word (FRAC_BITS fractional bits, Q16.16 by default) into an IEEE-754 single-precision float.
- Sits on the output side of the CORDIC core. It replaces the int_to_float + divide-by-2^16 pair with a single scaled conversion: the exponent is offset by FRAC_BITS, so no divider is needed.
- Uses the codebase's stb/ack handshake on both input and output.

Parameters:
FRAC_BITS, 16, number of fractional bits in input_a; legal range 0..31

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
input_a  input  32  signed fixed-point operand; value = input_a / 2^FRAC_BITS
input_a_stb  input  1  producer asserts when input_a is valid
input_a_ack  output  1  block ready to accept input_a
output_z  output  32  IEEE-754 single result {sign, exp[7:0], frac[22:0]}
output_z_stb  output  1  output_z valid
output_z_ack  input  1  consumer has taken output_z

Behaviour:
- Reset (rst low, asynchronous): state=GET_A, output_z=0, output_z_stb=0, input_a_ack=0, internal registers cleared. Any conversion in flight is abandoned.
- All outputs are registered. On the first rising edge with rst high, input_a_ack goes to 1.
- States: GET_A, UNPACK, NORMALISE, ROUND, PACK, PUT_Z.
- GET_A:
  - input_a_ack=1.
  - Accept edge = rising edge with input_a_stb & input_a_ack. On that edge: capture input_a, set input_a_ack<=0, go to UNPACK.
  - input_a is ignored in every other state.
- UNPACK (1 cycle):
  - sign = a[31]; m = |a| as 32-bit unsigned (0x80000000 gives magnitude 0x80000000); e = 31-FRAC_BITS (unbiased).
  - If a==0: output_z<=0x00000000 (+0), go to PUT_Z.
  - Else go to NORMALISE.
- NORMALISE:
  - While m[31]==0: m<=m<<1, e<=e-1, one bit per cycle.
  - When m[31]==1: go to ROUND.
  - Occupies lz+1 cycles, where lz = leading zeros of the magnitude.
- ROUND (1 cycle), round-to-nearest-even:
  - mant = m[31:8], guard = m[7], sticky = |m[6:0], lsb = m[8].
  - If guard & (sticky | lsb): mant = mant+1.
  - If that increment carries out of 24 bits: mant = 0x800000, e = e+1.
- PACK (1 cycle): output_z <= {sign, e+127 (8 bits), mant[22:0]}. Go to PUT_Z.
  - Exponent cannot over- or underflow for legal FRAC_BITS, so denormals, Inf and NaN are never produced.
  - Negative zero is never produced.
- PUT_Z:
  - output_z_stb=1; output_z is held stable until taken.
  - On an edge with output_z_stb & output_z_ack: output_z_stb<=0, input_a_ack<=1 on that same edge, state=GET_A.
  - output_z keeps its last value after the transfer.
  - Back-to-back transfers are allowed; there is no bubble beyond the state sequence.
- Latency, counted in rising edges from the accept edge to output_z_stb high:
  - nonzero input: lz+4
  - zero input: 1
- Throughput: one conversion in flight at a time. input_a_ack stays low from the accept edge until output_z is taken.
- output_z_ack while output_z_stb is low: ignored.
- input_a_stb while input_a_ack is low: ignored; the producer must hold its value.
- rst asserted during any state, including PUT_Z with stb high: output_z_stb drops immediately, with no pending transfer.

Test Plan:
- 0x00010000 (1.0) -> output_z=0x3F800000; stb 19 edges after accept (lz=15). 0xFFFF8000 (-0.5) -> 0xBF000000.
- 0x80000000 (-32768.0) -> 0xC7000000 after 4 edges. 0x00000000 -> 0x00000000 after 1 edge, output_z_stb high.
- Rounding, carry: 0x7FFFFFFF -> 0x47000000 (mantissa carry-out, exponent bump).
- Rounding, tie: 0x01000001 (tie, even) -> 0x43800000; 0x01000003 (tie, odd) -> 0x43800002.
- Handshake:
  - Hold output_z_ack low 10 cycles: output_z_stb and output_z stay constant, input_a_ack stays 0, and new input_a_stb pulses are ignored.
  - Then ack for 1 cycle and present the next operand immediately: it is accepted on the next edge.
- Pull rst low mid-NORMALISE (input 0x00000001): output_z=0, stb=0 and ack=0 asynchronously. After release, input_a_ack=1 on the first edge, and 0x00010000 then converts correctly to 0x3F800000.
